// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } arb_state_e;

  localparam int unsigned PORT_CPU = 0;
  localparam int unsigned PORT_AUX = 1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection for the two memory requesters.
// MEM_ARB_RR_EN: round-robin tie-break against the last winner; otherwise the CPU wins ties.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win,
  output logic       valid
);

  always_comb begin
    win   = '0;
    valid = |req;
    if (req == 2'b11) begin
`ifdef MEM_ARB_RR_EN
      win[PORT_CPU] = last;
      win[PORT_AUX] = ~last;
`else
      win[PORT_CPU] = 1'b1;
`endif
    end else begin
      win = req;
    end
  end

`ifndef MEM_ARB_RR_EN
  logic unused_last;
  assign unused_last = last;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for the unified instruction/data memory: fixed-latency
// transactions with registered grant/done pulses. Tie-break policy set by MEM_ARB_RR_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      req,
  input  logic [1:0]      we,
  input  logic [2*AW-1:0] addr,
  input  logic [2*DW-1:0] wdata,
  output logic [1:0]      gnt,
  output logic [1:0]      done,
  output logic [DW-1:0]   rdata,
  output logic            busy,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int unsigned CW = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);

  arb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [1:0]    done_q, done_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          busy_q, busy_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;

  logic [1:0] pick_win;
  logic       pick_valid;

  mem_arb_pick u_pick (
    .req   (req),
    .last  (last_q),
    .win   (pick_win),
    .valid (pick_valid)
  );

  // Outputs are computed from the next state so every strobe is a flop output.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    last_d      = last_q;
    gnt_d       = '0;
    done_d      = '0;
    rdata_d     = rdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          owner_d          = pick_win[PORT_AUX];
          last_d           = owner_d;
          cnt_d            = '0;
          state_d          = ACCESS;
          gnt_d[owner_d]   = 1'b1;
          mem_en_d         = 1'b1;
          mem_we_d         = we[owner_d];
          mem_addr_d       = owner_d ? addr[AW +: AW] : addr[0 +: AW];
          mem_wdata_d      = owner_d ? wdata[DW +: DW] : wdata[0 +: DW];
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d         = RESP;
          done_d[owner_q] = 1'b1;
          if (!mem_we_q) rdata_d = mem_rdata;
        end else begin
          mem_en_d = 1'b1;
          mem_we_d = mem_we_q;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      gnt_q       <= '0;
      done_q      <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed and random transactions against a
// transaction-level model with a bench-side memory array.
module tb_mem_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      req;
  logic [1:0]      we;
  logic [2*AW-1:0] addr;
  logic [2*DW-1:0] wdata;
  logic [1:0]      gnt;
  logic [1:0]      done;
  logic [DW-1:0]   rdata;
  logic            busy;
  logic            mem_en;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] mem_arr [256];
  logic [DW-1:0] rdata_m;
  logic          last_m;

  mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .done      (done),
    .rdata     (rdata),
    .busy      (busy),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick_model(input logic [1:0] r);
    if (r == 2'b10) return 1;
    if (r == 2'b11) begin
`ifdef MEM_ARB_RR_EN
      return (last_m == 1'b1) ? 0 : 1;
`else
      return 0;
`endif
    end
    return 0;
  endfunction

  // One complete transaction, entered and left just after a rising edge with the DUT idle.
  task automatic txn(input logic [1:0] r, input logic [1:0] w,
                     input logic [2*AW-1:0] a, input logic [2*DW-1:0] d);
    int p;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          ew;
    logic [1:0]    oh;
    req = r; we = w; addr = a; wdata = d; mem_rdata = $urandom;
    p  = pick_model(r);
    ea = a[p*AW +: AW];
    ed = d[p*DW +: DW];
    ew = w[p];
    oh = 2'b01 << p;
    last_m = p[0];
    @(posedge clk); #1;
    for (int c = 1; c <= LAT; c++) begin
      chk("gnt", gnt, (c == 1) ? oh : 2'b00);
      chk("mem_en", mem_en, 1'b1);
      chk("mem_we", mem_we, ew);
      chk("mem_addr", mem_addr, ea);
      chk("mem_wdata", mem_wdata, ed);
      chk("busy_acc", busy, 1'b1);
      chk("done_acc", done, 2'b00);
      // Anything the requesters do now must be ignored.
      req = 2'($urandom); we = 2'($urandom);
      addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
      mem_rdata = (c == LAT) ? mem_arr[ea[7:0]] : $urandom;
      @(posedge clk); #1;
    end
    if (!ew) rdata_m = mem_arr[ea[7:0]];
    chk("done", done, oh);
    chk("gnt_resp", gnt, 2'b00);
    chk("mem_en_resp", mem_en, 1'b0);
    chk("rdata", rdata, rdata_m);
    chk("busy_resp", busy, 1'b1);
    req = 2'b00;
    @(posedge clk); #1;
    chk("busy_idle", busy, 1'b0);
    chk("done_idle", done, 2'b00);
    chk("gnt_idle", gnt, 2'b00);
    chk("mem_en_idle", mem_en, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = $urandom;
    mem_arr[8'h40] = 32'hDEADBEEF;
    mem_arr[8'h44] = 32'h0BADF00D;
    rdata_m = '0;
    last_m  = 1'b1;
    reset = 1'b0; req = '0; we = '0; addr = '0; wdata = '0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_done", done, 2'b00);
    chk("rst_rdata", rdata, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, '0);
    chk("rst_mem_wdata", mem_wdata, '0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // No requests: stays idle.
    repeat (3) begin
      @(posedge clk); #1;
      chk("noreq_busy", busy, 1'b0);
      chk("noreq_gnt", gnt, 2'b00);
    end

    // Single read from the CPU, then an aux write that leaves rdata alone.
    txn(2'b01, 2'b00, {32'h0, 32'h40}, '0);
    txn(2'b10, 2'b10, {32'h80, 32'h0}, {32'h1234, 32'h0});

    // Ties: fixed priority always CPU, round-robin alternates starting with CPU.
    repeat (4) txn(2'b11, 2'b00, {32'h44, 32'h40}, '0);

    // Reset in the middle of an access.
    req = 2'b01; we = 2'b00; addr = {32'h0, 32'h10};
    @(posedge clk); #1;
    chk("rst_mid_gnt", gnt, 2'b01);
    chk("rst_mid_en", mem_en, 1'b1);
    reset = 1'b0; req = 2'b00;
    #1;
    chk("rst_mid_en_drop", mem_en, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    rdata_m = '0;
    last_m  = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_mid_done", done, 2'b00);
    end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_rdata", rdata, '0);
    txn(2'b11, 2'b11, {32'h44, 32'h40}, {32'h5, 32'h6});
    txn(2'b01, 2'b00, {32'h0, 32'h44}, '0);

    // Random traffic.
    for (int i = 0; i < 40; i++) begin
      txn(2'($urandom_range(1, 3)), 2'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
